round_judge_display: RTL and testbench

Round-judgement and presentation block for the finger-dance game.
- Compares the 4-bit target pattern with the player's 4-bit input.
- Holds the game-running state and updates it on each round boundary.
- Drives the 4-digit multiplexed 7-segment display (score in decimal, pattern in hex) and the status LEDs.
- Sits between the round timer / pattern / score registers and the board I/O.

---
 rtl/round_judge_display_pkg.sv | 37 +++
 rtl/round_judge_display_bin8_to_bcd.sv | 32 +++
 rtl/round_judge_display.sv | 109 ++++++++++
 tb/tb_round_judge_display.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/round_judge_display_pkg.sv
// Shared constants and helpers for the round judgement / display block.
// Holds the active-low 7-segment table and the dark-display values.
package round_judge_display_pkg;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    GS_IDLE = 1'b0,
    GS_RUN  = 1'b1
  } game_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always dark.
  function automatic logic [7:0] seg_code(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/round_judge_display_bin8_to_bcd.sv
// Combinational 8-bit binary to three BCD digits.
// Shift-and-add-3 over all eight input bits.
module bin8_to_bcd
  import round_judge_display_pkg::*;
(
  input  logic [7:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [19:0] sh;

  // Double-dabble: adjust any BCD nibble >= 5 before each shift.
  always_comb begin
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8] >= 4'd5)
        sh[11:8] = sh[11:8] + 4'd3;
      if (sh[15:12] >= 4'd5)
        sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5)
        sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
  end

  assign ones     = sh[11:8];
  assign tens     = sh[15:12];
  assign hundreds = sh[19:16];

endmodule

// File: rtl/round_judge_display.sv
// Round judgement, game-state tracking and 4-digit display scan.
// Score shown in decimal on digits 0-2, pattern in hex on digit 3.
module round_judge_display
  import round_judge_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       round_clk,
  input  logic       restart,
  input  logic [3:0] pattern,
  input  logic [3:0] user_input,
  input  logic [7:0] score,
  output logic       round_result,
  output logic       game_state,
  output logic [7:0] SEG,
  output logic [3:0] AN,
  output logic [7:0] LED
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

  logic          rc_q;
  logic          round_edge;
  game_t         state;
  game_t         state_nx;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    dig;
  logic [3:0]    hundreds;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [3:0]    digit_val;

  assign round_result = (pattern == user_input);
  assign round_edge   = round_clk & ~rc_q;

  // Delay round_clk one cycle for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) rc_q <= 1'b0;
    else     rc_q <= round_clk;
  end

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) state <= GS_IDLE;
    else     state <= state_nx;
  end

  // Restart wins over a round boundary; a boundary latches the verdict.
  always_comb begin
    state_nx = state;
    if (restart)
      state_nx = GS_RUN;
    else if (round_edge)
      state_nx = round_result ? GS_RUN : GS_IDLE;
  end

  // Game state output decode.
  always_comb begin
    game_state = (state == GS_RUN);
  end

  // Digit hold counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig      <= 2'd0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      dig      <= dig + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  bin8_to_bcd u_bcd (
    .bin      (score),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  // Select the value shown on the current digit.
  always_comb begin
    digit_val = ones;
    case (dig)
      2'd0: digit_val = ones;
      2'd1: digit_val = tens;
      2'd2: digit_val = hundreds;
      default: digit_val = pattern;
    endcase
  end

  // Registered anode and segment drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      AN  <= AN_OFF;
      SEG <= SEG_OFF;
    end else begin
      AN  <= ~(4'b0001 << dig);
      SEG <= seg_code(digit_val);
    end
  end

  assign LED = {round_result, game_state, 2'b00, pattern};

endmodule

// File: tb/tb_round_judge_display.sv
// Directed bench for round_judge_display with a display scoreboard.
// Expected AN/SEG pairs are queued per cycle and popped as the scan runs.
module tb_round_judge_display;

  localparam int DIV = 4;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } disp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       round_clk;
  logic       restart;
  logic [3:0] pattern;
  logic [3:0] user_input;
  logic [7:0] score;
  logic       round_result;
  logic       game_state;
  logic [7:0] SEG;
  logic [3:0] AN;
  logic [7:0] LED;

  int n_pass  = 0;
  int n_total = 0;

  disp_t exp_q[$];

  logic [7:0] ref_seg [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  round_judge_display #(.SCAN_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .round_clk    (round_clk),
    .restart      (restart),
    .pattern      (pattern),
    .user_input   (user_input),
    .score        (score),
    .round_result (round_result),
    .game_state   (game_state),
    .SEG          (SEG),
    .AN           (AN),
    .LED          (LED)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reset, release, and check a full scan plus wrap against the queue.
  task automatic run_scan(input logic [7:0] sc, input logic [3:0] pt,
                          input string tag);
    int v;
    int d;
    disp_t e;
    score   = sc;
    pattern = pt;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    chk({tag, "_an_rst"}, {4'h0, AN}, 8'h0F);
    chk({tag, "_seg_rst"}, SEG, 8'hFF);
    for (int k = 0; k < 4 * DIV + 1; k++) begin
      d = (k / DIV) % 4;
      case (d)
        0: v = sc % 10;
        1: v = (sc / 10) % 10;
        2: v = sc / 100;
        default: v = pt;
      endcase
      e.an  = ~(4'(1) << d);
      e.seg = ref_seg[v];
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      chk({tag, "_an"}, {4'h0, AN}, {4'h0, e.an});
      chk({tag, "_seg"}, SEG, e.seg);
    end
  endtask

  initial begin
    rst        = 1'b1;
    round_clk  = 1'b0;
    restart    = 1'b0;
    pattern    = 4'h0;
    user_input = 4'h0;
    score      = 8'd0;
    tick();
    tick();
    chk("reset_an", {4'h0, AN}, 8'h0F);
    chk("reset_seg", SEG, 8'hFF);
    chk("reset_gs", {7'd0, game_state}, 8'd0);

    pattern    = 4'h5;
    user_input = 4'h5;
    #1;
    chk("rr_match", {7'd0, round_result}, 8'd1);
    chk("led_match", LED, 8'h85);
    user_input = 4'h4;
    #1;
    chk("rr_miss", {7'd0, round_result}, 8'd0);
    chk("led_miss", LED, 8'h05);

    run_scan(8'd207, 4'hA, "s207");
    run_scan(8'd0, 4'h0, "s0");
    run_scan(8'd255, 4'hF, "s255");

    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_an", {4'h0, AN}, 8'h0F);
    chk("mid_rst_seg", SEG, 8'hFF);
    rst = 1'b0;
    tick();
    chk("mid_rst_dig0", {4'h0, AN}, 8'h0E);
    chk("mid_rst_seg0", SEG, 8'h92);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_gs", {7'd0, game_state}, 8'd1);
    pattern    = 4'h3;
    user_input = 4'h3;
    round_clk  = 1'b1;
    tick();
    chk("edge_match_gs", {7'd0, game_state}, 8'd1);
    round_clk  = 1'b0;
    tick();
    user_input = 4'h2;
    round_clk  = 1'b1;
    tick();
    chk("edge_miss_gs", {7'd0, game_state}, 8'd0);
    chk("led_over", LED, 8'h03);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("held_high_gs", {7'd0, game_state}, 8'd1);

    round_clk = 1'b0;
    tick();
    round_clk = 1'b1;
    tick();
    chk("end_again_gs", {7'd0, game_state}, 8'd0);
    round_clk = 1'b0;
    tick();
    restart   = 1'b1;
    round_clk = 1'b1;
    tick();
    restart   = 1'b0;
    chk("prio_restart_gs", {7'd0, game_state}, 8'd1);
    chk("led_prio", LED, 8'h43);
    rst     = 1'b1;
    restart = 1'b1;
    tick();
    chk("prio_rst_gs", {7'd0, game_state}, 8'd0);
    rst     = 1'b0;
    restart = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
